tdc_loop_ctrl: RTL
==================

# tdc_loop_ctrl

Loop controller for the ADPLL. It runs on the feedback clock and reads the 32-bit thermometer `up_error`/`dwn_error` codes from the sequential TDC phase detector. Each cycle it decodes them to a signed phase error and steers a saturating DCO control word through an acquire/lock state machine. It raises `locked` once the error has stayed inside a tolerance window long enough.

## Interface
- `CODE_W`, 8: width of the DCO control word.
- `LOCK_TOL`, 2: in-window threshold; in window when |err| <= LOCK_TOL.
- `UNLOCK_TOL`, 6: a single cycle with |err| > UNLOCK_TOL drops lock.
- `LOCK_CNT`, 16: consecutive in-window cycles (range 1..255) needed to declare lock.
- `TRK_SHIFT`, 2: arithmetic right shift applied to err in LOCK (reduced gain).

Ports:
- `fb_clk`, in, 1: clock.
- `reset_trig`, in, 1: reset, asynchronous, active-high.
- `enable`, in, 1: loop enable; level-sensitive.
- `up_error`, in, 32: UP thermometer code, ones packed from bit 0.
- `dwn_error`, in, 32: DWN thermometer code, ones packed from bit 0.
- `dco_code`, out, CODE_W: DCO control word.
- `err_out`, out, 7 signed: registered phase error, up_cnt − dwn_cnt.
- `state`, out, 2: 00 IDLE, 01 ACQ, 10 LOCK.
- `locked`, out, 1: high exactly while state == LOCK.

## Operation
Decode:
- Count = index of the first 0 scanning upward from bit 0, range 0..32.
- All-ones gives 32. Bits above the first 0 are ignored.

Pipeline:
- Stage 1 registers `up_cnt`/`dwn_cnt` (6 bit).
- Stage 2 registers `err_out` = up_cnt − dwn_cnt (range −32..+32).

DCO update:
- `dco_code` updates from `err_out`.
- ACQ: `dco_code += err_out`.
- LOCK: `dco_code += (err_out >>> TRK_SHIFT)`. The shift rounds toward −inf, so −1 >>> 2 = −1.
- Sum is computed at CODE_W+2 bits, then clamped to [0, 2^CODE_W − 1].
- Positive error (reference leads) raises `dco_code`.

State machine (driven by stage-2 `err_out`):
- IDLE: `dco_code` = MID = 2^(CODE_W−1); window counter = 0. Goes to ACQ on the first edge where `enable` = 1.
- ACQ: in-window increments the counter, out-of-window clears it. When the counter reaches LOCK_CNT−1 and the current cycle is in window, go to LOCK. The DCO update in that same cycle still uses ACQ gain.
- LOCK: |err_out| > UNLOCK_TOL goes to ACQ next edge, clears the counter, and applies LOCK gain on that cycle. Errors between LOCK_TOL and UNLOCK_TOL keep LOCK.
- `enable` = 0 in any state goes to IDLE next edge: `dco_code` returns to MID and the counter clears. The pipeline registers keep running.

Boundaries:
- Counter saturates at LOCK_CNT−1 and never wraps.
- At the ±32 error extremes `dco_code` saturates at 0 or 2^CODE_W−1 without wrap.
- `reset_trig` mid-operation immediately forces all registers to their reset values.

## Timing
- Reset values: `dco_code` = MID (0x80 for CODE_W = 8), `err_out` = 0, `state` = IDLE, `locked` = 0. Internal counts and counter are 0.
- Latency: codes sampled at edge N, `err_out` valid after edge N+1, `dco_code` reflects that error after edge N+2.
- `enable` rising at edge E gives `state` = ACQ after E. The first DCO update is at edge E+1.
- LOCK entry: `locked` rises on the edge that completes the LOCK_CNT-th consecutive in-window `err_out`.
- LOCK exit: `locked` falls one edge after the out-of-tolerance `err_out` is first visible.
- All outputs are registered; none are combinational from inputs.

## Configuration
- `TDC_BUBBLE_CORR_EN` defined:
  - Before decode, each code bit i is replaced by majority(b[i−1], b[i], b[i+1]), with b[−1] = 1 and b[32] = 0.
  - A single isolated 0 inside a run of ones (or a lone 1 above the run) is removed.
  - Adds no latency.
- Undefined: raw first-zero decode as specified above; the majority logic is absent.

## Test plan
- Reset: assert `reset_trig` mid-LOCK -> immediately `dco_code` = 0x80, `state` = 00, `locked` = 0, `err_out` = 0.
- Latency/sign: `enable` = 1, up = 0x000000FF, dwn = 0x0000000F -> `err_out` = +4 after 2 edges; `dco_code` 0x80 -> 0x84 -> 0x88 on subsequent edges (ACQ).
- Lock: drive err = +1 continuously (up = 0x3, dwn = 0x1) -> `locked` = 1 after exactly 16 in-window `err_out` cycles. Afterwards `dco_code` increments by 0 per cycle (1 >>> 2 = 0).
- Unlock/hysteresis: in LOCK, err = +5 for 10 cycles keeps `locked` = 1. One cycle of err = −7 -> `state` = ACQ next edge and the counter restarts.
- Saturation: up = 0xFFFFFFFF, dwn = 0 held -> `dco_code` climbs by 32 per cycle and clamps at 0xFF. Mirror case clamps at 0x00. `enable` = 0 -> 0x80 next edge.
- Bubble (with `TDC_BUBBLE_CORR_EN`): up = 0x000000FB, dwn = 0 -> `err_out` = +8. Without the macro -> +2.

Source files
------------

// File: rtl/tdc_loop_ctrl_if.sv
// tdc_loop_ctrl_if: TDC code / DCO control bundle of the ADPLL loop controller.
//   enable    : loop enable, level-sensitive (master -> slave)
//   up_error  : UP thermometer code, ones packed from bit 0 (master -> slave)
//   dwn_error : DWN thermometer code, ones packed from bit 0 (master -> slave)
//   dco_code  : DCO control word (slave -> master)
//   err_out   : registered signed phase error up_cnt - dwn_cnt (slave -> master)
//   state     : 00 IDLE, 01 ACQ, 10 LOCK (slave -> master)
//   locked    : high exactly while state is LOCK (slave -> master)
interface tdc_loop_ctrl_if #(
    parameter int CODE_W = 8
);
    logic                    enable;
    logic [31:0]             up_error;
    logic [31:0]             dwn_error;
    logic [CODE_W-1:0]       dco_code;
    logic signed [6:0]       err_out;
    logic [1:0]              state;
    logic                    locked;

    modport master (
        output enable, up_error, dwn_error,
        input  dco_code, err_out, state, locked
    );

    modport slave (
        input  enable, up_error, dwn_error,
        output dco_code, err_out, state, locked
    );
endinterface

// File: rtl/tdc_loop_ctrl.sv
// tdc_loop_ctrl: ADPLL loop controller - decodes TDC thermometer codes into a
// signed phase error and steers a saturating DCO word through IDLE/ACQ/LOCK.
//   fb_clk     : feedback clock
//   reset_trig : asynchronous active-high reset
//   bus        : tdc_loop_ctrl_if.slave (enable, up_error, dwn_error in;
//                dco_code, err_out, state, locked out)
// Build option: define TDC_BUBBLE_CORR_EN to add 3-bit majority bubble
// correction on both thermometer codes ahead of the decode (no added latency).
module tdc_loop_ctrl #(
    parameter int CODE_W     = 8,
    parameter int LOCK_TOL   = 2,
    parameter int UNLOCK_TOL = 6,
    parameter int LOCK_CNT   = 16,
    parameter int TRK_SHIFT  = 2
) (
    input  logic            fb_clk,
    input  logic            reset_trig,
    tdc_loop_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACQ  = 2'b01,
        LOCK = 2'b10
    } state_t;

    // Two guard bits cover both the negative excursion and the carry past 2^CODE_W-1.
    localparam int                SUM_W   = CODE_W + 2;
    localparam logic [CODE_W-1:0] MID     = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] MAX     = {CODE_W{1'b1}};
    localparam logic [7:0]        WIN_TOP = 8'(LOCK_CNT - 1);

    // Index of the first zero scanning up from bit 0; all-ones gives 32.
    function automatic logic [5:0] therm_count(input logic [31:0] c);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 31; i >= 0; i--) begin
            if (!c[i]) n = 6'(i);
        end
        return n;
    endfunction

`ifdef TDC_BUBBLE_CORR_EN
    // Majority of each bit with its neighbours; below bit 0 reads as 1, above bit 31 as 0.
    function automatic logic [31:0] bubble_fix(input logic [31:0] c);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = {c[30:0], 1'b1};
        hi = {1'b0, c[31:1]};
        return (c & lo) | (c & hi) | (lo & hi);
    endfunction
`endif

    logic [31:0]        up_clean;
    logic [31:0]        dwn_clean;
    logic [5:0]         up_cnt_q,  up_cnt_d;
    logic [5:0]         dwn_cnt_q, dwn_cnt_d;
    logic signed [6:0]  err_q,     err_d;
    logic [CODE_W-1:0]  dco_q,     dco_d;
    state_t             state_q,   state_d;
    logic [7:0]         win_cnt_q, win_cnt_d;
    logic               locked_q,  locked_d;

    logic               in_win;
    logic               out_tol;
    logic signed [6:0]  delta;
    logic [SUM_W-1:0]   sum;
    logic [CODE_W-1:0]  dco_step;

`ifdef TDC_BUBBLE_CORR_EN
    assign up_clean  = bubble_fix(bus.up_error);
    assign dwn_clean = bubble_fix(bus.dwn_error);
`else
    assign up_clean  = bus.up_error;
    assign dwn_clean = bus.dwn_error;
`endif

    // Decode, error and clamped DCO arithmetic.
    always_comb begin
        up_cnt_d  = therm_count(up_clean);
        dwn_cnt_d = therm_count(dwn_clean);
        err_d     = $signed({1'b0, up_cnt_q}) - $signed({1'b0, dwn_cnt_q});
        in_win    = (err_q >= -LOCK_TOL) && (err_q <= LOCK_TOL);
        out_tol   = (err_q < -UNLOCK_TOL) || (err_q > UNLOCK_TOL);
        // Arithmetic shift floors toward -inf, so small negative errors still pull down by 1.
        delta     = (state_q == LOCK) ? (err_q >>> TRK_SHIFT) : err_q;
        sum       = {2'b00, dco_q} + {{(SUM_W-7){delta[6]}}, delta};
        dco_step  = sum[SUM_W-1]             ? '0  :
                    (|sum[SUM_W-2:CODE_W])   ? MAX :
                                               sum[CODE_W-1:0];
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        dco_d     = dco_q;
        win_cnt_d = win_cnt_q;
        if (!bus.enable) begin
            state_d   = IDLE;
            dco_d     = MID;
            win_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = ACQ;
                    dco_d     = MID;
                    win_cnt_d = '0;
                end
                ACQ: begin
                    dco_d = dco_step;
                    // The counter holds at WIN_TOP; reaching it with one more in-window cycle locks.
                    if (!in_win) begin
                        win_cnt_d = '0;
                    end else if (win_cnt_q == WIN_TOP) begin
                        state_d = LOCK;
                    end else begin
                        win_cnt_d = win_cnt_q + 8'd1;
                    end
                end
                LOCK: begin
                    dco_d = dco_step;
                    if (out_tol) begin
                        state_d   = ACQ;
                        win_cnt_d = '0;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    dco_d     = MID;
                    win_cnt_d = '0;
                end
            endcase
        end
        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge fb_clk or posedge reset_trig) begin
        if (reset_trig) begin
            up_cnt_q  <= '0;
            dwn_cnt_q <= '0;
            err_q     <= '0;
            dco_q     <= MID;
            state_q   <= IDLE;
            win_cnt_q <= '0;
            locked_q  <= 1'b0;
        end else begin
            up_cnt_q  <= up_cnt_d;
            dwn_cnt_q <= dwn_cnt_d;
            err_q     <= err_d;
            dco_q     <= dco_d;
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            locked_q  <= locked_d;
        end
    end

    assign bus.dco_code = dco_q;
    assign bus.err_out  = err_q;
    assign bus.state    = state_q;
    assign bus.locked   = locked_q;
endmodule
